// File: rtl/ndn_pkg.sv
// Shared NDN router definitions: FSM encoding, response status/source codes
// and the field widths used on the PIT access path.
package ndn_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int META_W   = 8;
  localparam int ENTRY_W  = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_REJ = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  localparam logic SRC_INT = 1'b0;
  localparam logic SRC_DAT = 1'b1;

  // Interest requests carry their name length in the metadata byte.
  function automatic logic [META_W-1:0] int_meta(input logic [LEN_W-1:0] len);
    return {2'b01, len};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the interest path, bit 1 the data
// path. A tie goes to the requester that did not win last time.
module rr_arb2
  import ndn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  // Combinational grant: at most one bit set, only while enabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last_grant == SRC_DAT) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember who won so the other side wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= SRC_DAT;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/pit_access_arbiter.sv
// Shares the single PIT port between the interest and data requesters:
// grants one request, holds its strobe until the PIT completes, rejects or
// times out, then returns one tagged response pulse.
//
// Handshakes: a request transfers on a cycle where *_valid and *_ready are
// both high; ready is only offered in IDLE and never to both requesters.
// rsp_valid is a single-cycle pulse with no back-pressure.
module pit_access_arbiter
  import ndn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                int_valid,
  output logic                int_ready,
  input  logic [PREFIX_W-1:0] int_prefix,
  input  logic [LEN_W-1:0]    int_length,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [PREFIX_W-1:0] dat_prefix,
  input  logic [META_W-1:0]   dat_meta,
  output logic [PREFIX_W-1:0] pit_prefix,
  output logic [LEN_W-1:0]    pit_length,
  output logic [META_W-1:0]   pit_meta,
  output logic                pit_out_bit,
  output logic                pit_prefix_ready,
  input  logic [ENTRY_W-1:0]  pit_table_entry,
  input  logic                pit_in_bit,
  input  logic                pit_rejected,
  input  logic                pit_data_packet,
  output logic                rsp_valid,
  output logic                rsp_src,
  output logic [ENTRY_W-1:0]  rsp_entry,
  output logic [1:0]          rsp_status,
  output logic                rsp_data_packet,
  output logic                busy,
  output logic [CNT_W-1:0]    reject_count,
  output logic [CNT_W-1:0]    timeout_count
);

  // Timer counts WAIT cycles from 0; the last allowed one aborts.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t state_q, state_d;
  logic       src_q;
  logic [7:0] timer_q;
  logic [1:0] gnt;
  logic       accept;
  logic       wait_done;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state_q == S_IDLE),
    .req ({dat_valid, int_valid}),
    .gnt (gnt)
  );

  assign int_ready = gnt[0];
  assign dat_ready = gnt[1];
  assign accept    = |gnt;
  assign wait_done = pit_in_bit | pit_rejected | (timer_q == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one request in flight at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the winning request; held stable until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= SRC_INT;
      pit_prefix <= '0;
      pit_length <= '0;
      pit_meta   <= '0;
    end else if (state_q == S_IDLE && accept) begin
      if (gnt[1]) begin
        src_q      <= SRC_DAT;
        pit_prefix <= dat_prefix;
        pit_length <= '0;
        pit_meta   <= dat_meta;
      end else begin
        src_q      <= SRC_INT;
        pit_prefix <= int_prefix;
        pit_length <= int_length;
        pit_meta   <= int_meta(int_length);
      end
    end
  end

  // WAIT-cycle timer, cleared while the strobe is first issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_q == S_ISSUE) begin
      timer_q <= '0;
    end else if (state_q == S_WAIT) begin
      timer_q <= timer_q + 8'd1;
    end
  end

  // Capture the outcome when leaving WAIT; completion beats rejection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_src         <= SRC_INT;
      rsp_entry       <= '0;
      rsp_status      <= ST_OK;
      rsp_data_packet <= 1'b0;
    end else if (state_q == S_WAIT && wait_done) begin
      rsp_src <= src_q;
      if (pit_in_bit) begin
        rsp_entry       <= pit_table_entry;
        rsp_status      <= ST_OK;
        rsp_data_packet <= pit_data_packet;
      end else begin
        rsp_entry       <= '0;
        rsp_status      <= pit_rejected ? ST_REJ : ST_TMO;
        rsp_data_packet <= 1'b0;
      end
    end
  end

  // Saturating statistics, bumped once per response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_count  <= '0;
      timeout_count <= '0;
    end else if (state_q == S_RESP) begin
      if (rsp_status == ST_REJ && reject_count != '1) begin
        reject_count <= reject_count + 1'b1;
      end
      if (rsp_status == ST_TMO && timeout_count != '1) begin
        timeout_count <= timeout_count + 1'b1;
      end
    end
  end

  assign pit_out_bit      = (state_q == S_ISSUE || state_q == S_WAIT) && (src_q == SRC_INT);
  assign pit_prefix_ready = (state_q == S_ISSUE || state_q == S_WAIT) && (src_q == SRC_DAT);
  assign rsp_valid        = (state_q == S_RESP);
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_pit_access_arbiter.sv
// Bench for pit_access_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model and an expected-response queue.
module tb_pit_access_arbiter;
  import ndn_pkg::*;

  localparam int TMO   = 15;
  localparam int CNT_W = 16;
  localparam int K_OK = 0, K_REJ = 1, K_BOTH = 2, K_SIL = 3;

  logic                clk, rst;
  logic                int_valid, int_ready, dat_valid, dat_ready;
  logic [PREFIX_W-1:0] int_prefix, dat_prefix, pit_prefix;
  logic [LEN_W-1:0]    int_length, pit_length;
  logic [META_W-1:0]   dat_meta, pit_meta;
  logic                pit_out_bit, pit_prefix_ready;
  logic [ENTRY_W-1:0]  pit_table_entry, rsp_entry;
  logic                pit_in_bit, pit_rejected, pit_data_packet;
  logic                rsp_valid, rsp_src, rsp_data_packet, busy;
  logic [1:0]          rsp_status;
  logic [CNT_W-1:0]    reject_count, timeout_count;

  pit_access_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_ready(int_ready), .int_prefix(int_prefix), .int_length(int_length),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_prefix(dat_prefix), .dat_meta(dat_meta),
    .pit_prefix(pit_prefix), .pit_length(pit_length), .pit_meta(pit_meta),
    .pit_out_bit(pit_out_bit), .pit_prefix_ready(pit_prefix_ready),
    .pit_table_entry(pit_table_entry), .pit_in_bit(pit_in_bit), .pit_rejected(pit_rejected),
    .pit_data_packet(pit_data_packet),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_entry(rsp_entry), .rsp_status(rsp_status),
    .rsp_data_packet(rsp_data_packet), .busy(busy),
    .reject_count(reject_count), .timeout_count(timeout_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who won last, statistic totals, expected responses
  // packed as {src, status[1:0], data_packet, entry[10:0]}.
  logic        m_last;
  int          m_rej, m_tmo;
  logic [14:0] exp_q[$];

  typedef struct {
    logic              gi, gd;
    logic              iss_out, iss_pr, busy_iss;
    logic [63:0]       pfx;
    logic [5:0]        len;
    logic [7:0]        meta;
    int                n_out, n_pr, rsp_k;
    logic              src, dp, strobe_at_rsp, rsp_after, busy_after;
    logic [1:0]        st;
    logic [10:0]       ent;
    logic [CNT_W-1:0]  rc, tc;
  } obs_t;

  task automatic apply_reset();
    rst = 1'b1;
    int_valid = 0; dat_valid = 0; int_prefix = '0; dat_prefix = '0;
    int_length = '0; dat_meta = '0;
    pit_table_entry = '0; pit_in_bit = 0; pit_rejected = 0; pit_data_packet = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_last = SRC_DAT; m_rej = 0; m_tmo = 0;
    exp_q.delete();
  endtask

  // Model of one transaction outcome, computed from the arbitration and
  // completion rules; returns the expected winner.
  task automatic model_txn(input logic iv, input logic dv, input int kind,
                           input logic dpkt, input logic [10:0] ent, output logic win);
    logic [1:0]  st;
    logic        p;
    logic [10:0] e;
    if (iv && dv) win = ~m_last;
    else          win = dv;
    m_last = win;
    case (kind)
      K_REJ:   begin st = 2'b01; e = '0;  p = 1'b0; if (m_rej < 65535) m_rej++; end
      K_SIL:   begin st = 2'b10; e = '0;  p = 1'b0; if (m_tmo < 65535) m_tmo++; end
      default: begin st = 2'b00; e = ent; p = dpkt; end
    endcase
    exp_q.push_back({win, st, p, e});
  endtask

  // Driver: offer a request, answer the PIT on WAIT cycle 'lat', collect
  // what the DUT did.
  task automatic drive_txn(input logic iv, input logic dv, input logic [63:0] ip,
                           input logic [63:0] dpf, input logic [5:0] il, input logic [7:0] dm,
                           input int kind, input int lat, input logic dpkt,
                           input logic [10:0] ent, output obs_t o);
    o.n_out = 0; o.n_pr = 0; o.rsp_k = -1;
    o.src = 0; o.dp = 0; o.st = 0; o.ent = 0; o.strobe_at_rsp = 0;
    @(negedge clk);
    int_valid = iv; dat_valid = dv; int_prefix = ip; dat_prefix = dpf;
    int_length = il; dat_meta = dm;
    #1;
    o.gi = int_ready; o.gd = dat_ready;
    @(negedge clk);
    int_valid = 0; dat_valid = 0;
    o.iss_out = pit_out_bit; o.iss_pr = pit_prefix_ready; o.busy_iss = busy;
    o.pfx = pit_prefix; o.len = pit_length; o.meta = pit_meta;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        o.rsp_k = k; o.src = rsp_src; o.st = rsp_status; o.dp = rsp_data_packet;
        o.ent = rsp_entry; o.strobe_at_rsp = pit_out_bit | pit_prefix_ready;
        break;
      end
      if (pit_out_bit)      o.n_out++;
      if (pit_prefix_ready) o.n_pr++;
      if (k == lat && kind != K_SIL) begin
        pit_in_bit      = (kind != K_REJ);
        pit_rejected    = (kind != K_OK);
        pit_data_packet = dpkt;
        pit_table_entry = ent;
      end else begin
        pit_in_bit = 0; pit_rejected = 0; pit_data_packet = 0; pit_table_entry = '0;
      end
    end
    pit_in_bit = 0; pit_rejected = 0; pit_data_packet = 0; pit_table_entry = '0;
    @(negedge clk);
    o.rsp_after = rsp_valid; o.busy_after = busy;
    o.rc = reject_count; o.tc = timeout_count;
  endtask

  task automatic test_reset();
    checks++;
    if ({int_ready, dat_ready, pit_out_bit, pit_prefix_ready, rsp_valid, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=000000",
        {int_ready, dat_ready, pit_out_bit, pit_prefix_ready, rsp_valid, busy});
    end
    checks++;
    if ({pit_prefix, pit_length, pit_meta} !== '0) begin
      errors++; $display("FAIL reset_pit got=%h want=0", {pit_prefix, pit_length, pit_meta});
    end
    checks++;
    if ({rsp_src, rsp_entry, rsp_status, rsp_data_packet, reject_count, timeout_count} !== '0) begin
      errors++; $display("FAIL reset_rsp got=%h want=0",
        {rsp_src, rsp_entry, rsp_status, rsp_data_packet, reject_count, timeout_count});
    end
  endtask

  task automatic test_interest_only();
    obs_t o; logic w; logic [14:0] e;
    model_txn(1, 0, K_OK, 0, 11'h005, w);
    drive_txn(1, 0, 64'hA5, '0, 6'd12, '0, K_OK, 1, 0, 11'h005, o);
    e = exp_q.pop_front();
    checks++;
    if ({o.gi, o.gd, o.iss_out, o.iss_pr} !== 4'b1010) begin
      errors++; $display("FAIL int_grant_strobe got=%b want=1010", {o.gi, o.gd, o.iss_out, o.iss_pr});
    end
    checks++;
    if (o.meta !== 8'h4C || o.pfx !== 64'hA5 || o.len !== 6'd12) begin
      errors++; $display("FAIL int_pit_fields got=%h/%h/%h want=4c/a5/0c", o.meta, o.pfx, o.len);
    end
    checks++;
    if (o.rsp_k !== 2) begin
      errors++; $display("FAIL int_latency got=%0d want=2", o.rsp_k);
    end
    checks++;
    if ({o.src, o.st, o.dp, o.ent} !== e || o.ent !== 11'h005 || o.rsp_after !== 1'b0) begin
      errors++; $display("FAIL int_rsp got=%h pulse_after=%b want=%h", {o.src, o.st, o.dp, o.ent}, o.rsp_after, e);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o; logic w; logic [14:0] e;
    for (int i = 0; i < 3; i++) begin
      model_txn(1, 1, K_OK, 0, 11'(i + 1), w);
      drive_txn(1, 1, 64'h100 + 64'(i), 64'h200 + 64'(i), 6'd3, 8'h77, K_OK, 2, 0, 11'(i + 1), o);
      e = exp_q.pop_front();
      checks++;
      if ({o.gd, o.gi} !== {w, ~w} || w !== ((i == 1) ? SRC_DAT : SRC_INT)) begin
        errors++; $display("FAIL tie_grant%0d got=%b%b want=%b%b", i, o.gd, o.gi, w, ~w);
      end
      checks++;
      if ({o.src, o.st, o.dp, o.ent} !== e) begin
        errors++; $display("FAIL tie_rsp%0d got=%h want=%h", i, {o.src, o.st, o.dp, o.ent}, e);
      end
    end
  endtask

  task automatic test_reject();
    obs_t o; logic w; logic [14:0] e;
    model_txn(0, 1, K_REJ, 0, 11'h3FF, w);
    drive_txn(0, 1, '0, 64'hDEAD_BEEF, '0, 8'h5A, K_REJ, 3, 0, 11'h3FF, o);
    e = exp_q.pop_front();
    checks++;
    if ({o.src, o.st, o.ent} !== {1'b1, 2'b01, 11'h0} || {o.src, o.st, o.dp, o.ent} !== e) begin
      errors++; $display("FAIL rej_rsp got=%h want=%h", {o.src, o.st, o.dp, o.ent}, e);
    end
    checks++;
    if (o.rc !== CNT_W'(m_rej) || m_rej != 1) begin
      errors++; $display("FAIL rej_count got=%0d want=%0d", o.rc, m_rej);
    end
    checks++;
    if (o.pfx !== 64'hDEAD_BEEF || o.len !== 6'd0 || o.meta !== 8'h5A || o.iss_pr !== 1'b1) begin
      errors++; $display("FAIL dat_pit_fields got=%h/%h/%h/%b", o.pfx, o.len, o.meta, o.iss_pr);
    end
  endtask

  task automatic test_timeout();
    obs_t o; logic w; logic [14:0] e;
    model_txn(1, 0, K_SIL, 0, '0, w);
    drive_txn(1, 0, 64'h1234, '0, 6'd5, '0, K_SIL, 0, 0, '0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.rsp_k !== TMO + 1 || o.n_out !== TMO || o.strobe_at_rsp !== 1'b0) begin
      errors++; $display("FAIL tmo_timing got=rsp@%0d strobe_wait=%0d strobe_rsp=%b want=rsp@%0d strobe_wait=%0d strobe_rsp=0",
        o.rsp_k, o.n_out, o.strobe_at_rsp, TMO + 1, TMO);
    end
    checks++;
    if ({o.src, o.st, o.dp, o.ent} !== e || o.tc !== CNT_W'(m_tmo)) begin
      errors++; $display("FAIL tmo_rsp got=%h cnt=%0d want=%h cnt=%0d", {o.src, o.st, o.dp, o.ent}, o.tc, e, m_tmo);
    end
  endtask

  task automatic test_both_complete();
    obs_t o; logic w; logic [14:0] e;
    model_txn(0, 1, K_BOTH, 1, 11'h2A1, w);
    drive_txn(0, 1, '0, 64'hCAFE, '0, 8'h11, K_BOTH, 2, 1, 11'h2A1, o);
    e = exp_q.pop_front();
    checks++;
    if (o.st !== 2'b00 || o.dp !== 1'b1 || {o.src, o.st, o.dp, o.ent} !== e) begin
      errors++; $display("FAIL both_rsp got=%h want=%h", {o.src, o.st, o.dp, o.ent}, e);
    end
    checks++;
    if (o.rc !== CNT_W'(m_rej)) begin
      errors++; $display("FAIL both_rej_count got=%0d want=%0d", o.rc, m_rej);
    end
  endtask

  task automatic test_random();
    obs_t o; logic w; logic [14:0] e;
    logic iv, dv, dpkt; int kind, lat; logic [63:0] ip, dpf; logic [5:0] il; logic [7:0] dm;
    logic [10:0] ent;
    for (int i = 0; i < 24; i++) begin
      iv = 1'($urandom_range(0, 1)); dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) iv = 1;
      kind = $urandom_range(0, 3); lat = $urandom_range(1, 8);
      ip = {$urandom, $urandom}; dpf = {$urandom, $urandom};
      il = 6'($urandom); dm = 8'($urandom); ent = 11'($urandom);
      dpkt = (kind == K_REJ) ? 1'b0 : 1'($urandom_range(0, 1));
      model_txn(iv, dv, kind, dpkt, ent, w);
      drive_txn(iv, dv, ip, dpf, il, dm, kind, lat, dpkt, ent, o);
      e = exp_q.pop_front();
      checks++;
      if ({o.gd, o.gi, o.iss_pr, o.iss_out, o.busy_iss} !== {w, ~w, w, ~w, 1'b1}) begin
        errors++; $display("FAIL rnd%0d_grant got=%b want=%b", i,
          {o.gd, o.gi, o.iss_pr, o.iss_out, o.busy_iss}, {w, ~w, w, ~w, 1'b1});
      end
      checks++;
      if (o.pfx !== (w ? dpf : ip) || o.len !== (w ? 6'd0 : il) || o.meta !== (w ? dm : {2'b01, il})) begin
        errors++; $display("FAIL rnd%0d_pit got=%h/%h/%h", i, o.pfx, o.len, o.meta);
      end
      checks++;
      if (o.rsp_k !== ((kind == K_SIL) ? TMO + 1 : lat + 1)
          || (w ? o.n_pr : o.n_out) !== ((kind == K_SIL) ? TMO : lat)
          || (w ? o.n_out : o.n_pr) !== 0 || o.strobe_at_rsp !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_timing got=rsp@%0d out=%0d pr=%0d want rsp@%0d", i,
          o.rsp_k, o.n_out, o.n_pr, (kind == K_SIL) ? TMO + 1 : lat + 1);
      end
      checks++;
      if ({o.src, o.st, o.dp, o.ent} !== e || o.rsp_after !== 1'b0 || o.busy_after !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_rsp got=%h after=%b busy=%b want=%h", i,
          {o.src, o.st, o.dp, o.ent}, o.rsp_after, o.busy_after, e);
      end
      checks++;
      if (o.rc !== CNT_W'(m_rej) || o.tc !== CNT_W'(m_tmo)) begin
        errors++; $display("FAIL rnd%0d_counts got=%0d/%0d want=%0d/%0d", i, o.rc, o.tc, m_rej, m_tmo);
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t o; logic w; logic [14:0] e; int seen;
    @(negedge clk);
    int_valid = 1; int_prefix = 64'h77; int_length = 6'd9;
    @(negedge clk);
    int_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pit_out_bit, pit_prefix_ready, busy, rsp_valid, pit_prefix, pit_meta, reject_count, timeout_count} !== '0) begin
      errors++; $display("FAIL midrst_zero got=%b%b%b%b pfx=%h rc=%0d tc=%0d want=all zero",
        pit_out_bit, pit_prefix_ready, busy, rsp_valid, pit_prefix, reject_count, timeout_count);
    end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      if (k == 1) rst = 1'b0;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_norsp got=%0d pulses want=0", seen);
    end
    m_last = SRC_DAT; m_rej = 0; m_tmo = 0;
    model_txn(1, 1, K_OK, 1, 11'h0AB, w);
    drive_txn(1, 1, 64'h99, 64'h88, 6'd4, 8'h22, K_OK, 1, 1, 11'h0AB, o);
    e = exp_q.pop_front();
    checks++;
    if ({o.src, o.st, o.dp, o.ent} !== e || o.rsp_k !== 2 || o.rc !== '0 || o.tc !== '0) begin
      errors++; $display("FAIL midrst_after got=%h rsp@%0d rc=%0d tc=%0d want=%h rsp@2 0 0",
        {o.src, o.st, o.dp, o.ent}, o.rsp_k, o.rc, o.tc, e);
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_interest_only();
    apply_reset();
    test_simultaneous();
    test_reject();
    test_timeout();
    test_both_complete();
    test_random();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pit_access_arbiter.md
Name: pit_access_arbiter

Overview:
Sequences and shares the single PIT hash-table port between two requesters: the interest path from the user side and the data path from the FIB side.
- Arbitrates round-robin between them and latches the winning request.
- Drives the PIT strobes and holds them until the PIT completes or a timeout fires.
- Returns one tagged response per request.
- Sits between the ingress/FIB front-ends and pit_hash_table in the NDN router.

Parameters:
TIMEOUT_CYCLES, 15, cycles in WAIT with no PIT completion before an abort with timeout status (1..255)
CNT_W, 16, width of the saturating reject/timeout statistic counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
int_valid  in  1  interest request pending
int_ready  out  1  interest request accepted this cycle
int_prefix  in  64  interest name prefix
int_length  in  6  interest name length
dat_valid  in  1  data request pending (from FIB)
dat_ready  out  1  data request accepted this cycle
dat_prefix  in  64  data name prefix
dat_meta  in  8  data metadata byte
pit_prefix  out  64  prefix presented to PIT (latched)
pit_length  out  6  length presented to PIT
pit_meta  out  8  metadata presented to PIT
pit_out_bit  out  1  interest strobe to PIT
pit_prefix_ready  out  1  data strobe to PIT
pit_table_entry  in  11  PIT entry result
pit_in_bit  in  1  PIT completion (hit/insert)
pit_rejected  in  1  PIT rejected unsolicited data
pit_data_packet  in  1  PIT flagged data match to pending interest
rsp_valid  out  1  one-cycle response pulse
rsp_src  out  1  0 = interest, 1 = data
rsp_entry  out  11  table entry returned
rsp_status  out  2  00 ok, 01 rejected, 10 timeout
rsp_data_packet  out  1  copy of pit_data_packet at completion
busy  out  1  high in every state but IDLE
reject_count  out  CNT_W  saturating count of rejected responses
timeout_count  out  CNT_W  saturating count of timeout responses

Behaviour:
- Reset (async) values:
  - State is IDLE; last_grant = data, so interest wins the first tie.
  - All outputs are 0, and both counters are 0.
  - Reset mid-transaction drops the request with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant logic is combinational: `int_ready`/`dat_ready` are high only in IDLE, for at most one requester.
  - Single valid: that requester wins. Both valid: the one not equal to last_grant wins.
  - On valid&ready: latch prefix, length and meta into the pit_* registers. For an interest, pit_meta = {2'b01, int_length}; for data, pit_length = 0. Record src, update last_grant, go to ISSUE.
- ISSUE (1 cycle):
  - Assert `pit_out_bit` (interest) or `pit_prefix_ready` (data).
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - The strobe stays high and the timer increments each cycle.
  - `pit_in_bit` high: capture `pit_table_entry` and `pit_data_packet`, status 00.
  - `pit_rejected` high: status 01, entry 0.
  - Both high at once: `pit_in_bit` takes priority.
  - Timer == TIMEOUT_CYCLES with no completion: status 10, entry 0.
  - Any of the three: drop the strobe and go to RESP.
- RESP (1 cycle):
  - `rsp_valid` = 1 with the registered src/entry/status/data_packet.
  - Increment the matching counter, saturating at all-ones.
  - Go to IDLE; rsp_* other than `rsp_valid` hold their value until the next RESP.
- Latency: accept -> strobe 1 cycle; PIT completion -> `rsp_valid` 1 cycle. Minimum accept-to-response is 3 cycles.
- Back-to-back: next grant is possible in the cycle after RESP, so throughput is 1 request per 4+ cycles.
- A requester that drops valid before ready is simply not granted; no glitch requirement applies.
- `pit_*` data outputs are stable from ISSUE through RESP.
- `pit_in_bit`/`pit_rejected` are ignored outside WAIT.

Decomposition:
- Shared package `ndn_pkg`:
  - state encoding (IDLE/ISSUE/WAIT/RESP)
  - status codes (ST_OK=2'b00, ST_REJ=2'b01, ST_TMO=2'b10)
  - src codes (SRC_INT=0, SRC_DAT=1)
  - widths: PREFIX_W=64, LEN_W=6, META_W=8, ENTRY_W=11
- One sub-module is natural: `rr_arb2`, a 2-way round-robin arbiter with valid inputs, last_grant register and grant outputs. The FSM, timer and counters stay in the top.

Test Plan:
1. Interest only: int_valid, prefix 64'hA5, length 6'd12. Required: int_ready in the same cycle; pit_out_bit high the next cycle with pit_meta=8'h4C. With pit_in_bit and entry 11'h005 two cycles later, rsp_valid pulses once with src=0, entry=11'h005, status=00.
2. Simultaneous int_valid and dat_valid from reset. Required: interest granted first, data granted in the first IDLE after; the third simultaneous pair again goes to interest.
3. Data with pit_rejected=1 in WAIT. Required: rsp src=1, status=01, entry=0; reject_count increments 0->1.
4. Interest with the PIT silent and TIMEOUT_CYCLES=15. Required: strobe drops and rsp status=10 exactly 15 WAIT cycles after entry; timeout_count=1.
5. pit_in_bit and pit_rejected high together, with pit_data_packet=1 on a data request. Required: status=00 and rsp_data_packet=1.
6. rst asserted in WAIT. Required: outputs zero immediately and no rsp_valid. A new request after rst release completes normally with counters at 0.
